// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: sweeps every N_IN-bit vector into a combinational DUT,
// compares its response against a golden model and builds a mismatch summary and signature.
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1,
   parameter int SIG_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [N_IN-1:0]   stim,
   input  logic [N_OUT-1:0]  resp,
   input  logic [N_OUT-1:0]  exp,
   output logic              busy,
   output logic              done,
   output logic [N_IN:0]     err_cnt,
   output logic              fail_valid,
   output logic [N_IN-1:0]   first_fail,
   output logic [SIG_W-1:0]  signature
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             settled;
   logic             last_vec;
   logic             mismatch;

   assign settled  = (cnt == CNT_W'(SETTLE - 1));
   assign last_vec = (stim == {N_IN{1'b1}});
   assign mismatch = (resp != exp);
   assign busy     = (state == APPLY) || (state == SAMPLE);
   assign done     = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // abort outranks both the settle exit and the final-vector completion
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = APPLY;
         APPLY:   if (abort) state_next = IDLE;
                  else if (settled) state_next = SAMPLE;
         SAMPLE:  if (abort) state_next = IDLE;
                  else if (last_vec) state_next = DONE;
                  else state_next = APPLY;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stim       <= '0;
         cnt        <= '0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         first_fail <= '0;
         signature  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               stim       <= '0;
               cnt        <= '0;
               err_cnt    <= '0;
               fail_valid <= 1'b0;
               first_fail <= '0;
               signature  <= '0;
            end
            APPLY: begin
               if (abort)         stim <= '0;
               else if (!settled) cnt  <= cnt + CNT_W'(1);
            end
            SAMPLE: begin
               if (abort) begin
                  stim <= '0;
               end else begin
                  if (mismatch) begin
                     err_cnt <= err_cnt + (N_IN+1)'(1);
                     if (!fail_valid) begin
                        first_fail <= stim;
                        fail_valid <= 1'b1;
                     end
                  end
                  signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ SIG_W'(resp);
                  // the last vector wraps stim back to zero on its way to DONE
                  stim      <= stim + N_IN'(1);
                  cnt       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table-driven full sweeps with a parity golden model,
// plus hand-written abort, reset and longer-settle sequences.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // SETTLE=1 instance
   logic        start, abort;
   logic [3:0]  stim;
   logic        resp, exp;
   logic        busy, done, fail_valid;
   logic [4:0]  err_cnt;
   logic [3:0]  first_fail;
   logic [15:0] signature;
   logic [15:0] fault_mask;
   logic        force_one;

   // SETTLE=3 instance
   logic        start3, abort3;
   logic [3:0]  stim3;
   logic        resp3, exp3;
   logic        busy3, done3, fail_valid3;
   logic [4:0]  err_cnt3;
   logic [3:0]  first_fail3;
   logic [15:0] signature3;

   assign exp   = ^stim;
   assign resp  = force_one ? 1'b1 : ((^stim) ^ fault_mask[stim]);
   assign exp3  = ^stim3;
   assign resp3 = ^stim3;

   truth_table_sweeper #(.N_IN(4), .N_OUT(1), .SETTLE(1), .SIG_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .stim(stim),
      .resp(resp), .exp(exp), .busy(busy), .done(done), .err_cnt(err_cnt),
      .fail_valid(fail_valid), .first_fail(first_fail), .signature(signature)
   );

   truth_table_sweeper #(.N_IN(4), .N_OUT(1), .SETTLE(3), .SIG_W(16)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3), .stim(stim3),
      .resp(resp3), .exp(exp3), .busy(busy3), .done(done3), .err_cnt(err_cnt3),
      .fail_valid(fail_valid3), .first_fail(first_fail3), .signature(signature3)
   );

   int checks = 0;
   int errors = 0;
   int cycle;

   typedef struct {
      logic [15:0] mask;
      logic        one;
      int          e_err;
      logic        e_fv;
      int          e_ff;
      logic [15:0] e_sig;
   } vec_t;

   vec_t vecs[5];

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // pulse start for one edge (E0); returns at the falling edge of cycle 1
   task automatic applyStimulus(input logic [15:0] mask, input logic one);
      fault_mask = mask;
      force_one  = one;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycle = 1;
   endtask

   task automatic waitDone(output int busy_cycles, output int done_cycle);
      busy_cycles = 0;
      done_cycle  = -1;
      for (int i = 0; i < 200; i++) begin
         if (busy) busy_cycles++;
         if (force_one && cycle == 9)
            checkOutput("sig_after_4_vectors", signature, 16'h000F);
         if (done) begin
            done_cycle = cycle;
            break;
         end
         @(negedge clk);
         cycle++;
      end
   endtask

   initial begin
      int bc, dc, hold5, found;
      bit done_seen;

      // parity of 0..15 read MSB-first gives 0x6996
      vecs[0] = '{16'h0000, 1'b0, 0,  1'b0, 0, 16'h6996};
      vecs[1] = '{16'h1020, 1'b0, 2,  1'b1, 5, 16'h6D9E};
      vecs[2] = '{16'h0000, 1'b1, 8,  1'b1, 0, 16'hFFFF};
      vecs[3] = '{16'h8001, 1'b0, 2,  1'b1, 0, 16'hE997};
      vecs[4] = '{16'hFFFF, 1'b0, 16, 1'b1, 0, 16'h9669};

      rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
      fault_mask = '0; force_one = 1'b0;
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_stim", stim, 0);
      checkOutput("reset_err_cnt", err_cnt, 0);
      checkOutput("reset_sig", signature, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].mask, vecs[v].one);
         checkOutput($sformatf("vec%0d_stim_start", v), stim, 0);
         waitDone(bc, dc);
         checkOutput($sformatf("vec%0d_busy_cycles", v), bc, 32);
         checkOutput($sformatf("vec%0d_done_cycle", v), dc, 33);
         checkOutput($sformatf("vec%0d_err_cnt", v), err_cnt, vecs[v].e_err);
         checkOutput($sformatf("vec%0d_fail_valid", v), fail_valid, vecs[v].e_fv);
         checkOutput($sformatf("vec%0d_first_fail", v), first_fail, vecs[v].e_ff);
         checkOutput($sformatf("vec%0d_signature", v), signature, vecs[v].e_sig);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_one_cycle", v), done, 0);
      end
      force_one = 1'b0;

      // abort at stim=7 after a mismatch at stim=3
      applyStimulus(16'h0008, 1'b0);
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (stim == 4'd7) found = 1;
         else @(negedge clk);
      end
      checkOutput("abort_reached_stim7", found, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_stim", stim, 0);
      checkOutput("abort_err_cnt", err_cnt, 1);
      checkOutput("abort_fail_valid", fail_valid, 1);
      checkOutput("abort_first_fail", first_fail, 3);
      done_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (done) done_seen = 1'b1;
         @(negedge clk);
      end
      checkOutput("abort_no_done", done_seen, 0);
      applyStimulus(16'h0000, 1'b0);
      checkOutput("restart_err_cleared", err_cnt, 0);
      checkOutput("restart_fv_cleared", fail_valid, 0);
      waitDone(bc, dc);
      checkOutput("restart_busy_cycles", bc, 32);
      checkOutput("restart_err_cnt", err_cnt, 0);

      // asynchronous reset in the SAMPLE cycle of stim=9
      @(negedge clk);
      applyStimulus(16'h0004, 1'b0);
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (stim == 4'd9) found = 1;
         else @(negedge clk);
      end
      checkOutput("rst_reached_stim9", found, 1);
      @(negedge clk);
      checkOutput("rst_pre_err_cnt", err_cnt, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_async_busy", busy, 0);
      checkOutput("rst_async_stim", stim, 0);
      checkOutput("rst_async_err_cnt", err_cnt, 0);
      checkOutput("rst_async_fail_valid", fail_valid, 0);
      checkOutput("rst_async_first_fail", first_fail, 0);
      checkOutput("rst_async_sig", signature, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(16'h0000, 1'b0);
      checkOutput("rst_restart_stim", stim, 0);
      checkOutput("rst_restart_busy", busy, 1);
      waitDone(bc, dc);
      checkOutput("rst_restart_done_cycle", dc, 33);
      checkOutput("rst_restart_sig", signature, 16'h6996);

      // SETTLE=3: done rises at edge E0+64, so it is seen in cycle 65; start mid-sweep ignored
      @(negedge clk);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      cycle = 1; bc = 0; dc = -1; hold5 = 0;
      for (int i = 0; i < 300 && dc < 0; i++) begin
         if (busy3) bc++;
         if (busy3 && stim3 == 4'd5) hold5++;
         if (done3) dc = cycle;
         else begin
            start3 = (cycle == 20);
            @(negedge clk);
            cycle++;
         end
      end
      start3 = 1'b0;
      checkOutput("s3_busy_cycles", bc, 64);
      checkOutput("s3_done_cycle", dc, 65);
      checkOutput("s3_vector5_hold", hold5, 4);
      checkOutput("s3_err_cnt", err_cnt3, 0);
      checkOutput("s3_signature", signature3, 16'h6996);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, synthesizable exhaustive-stimulus engine for combinational blocks. After a start pulse it drives every input vector 0..2^N_IN-1 onto a device under test and waits a programmable settle time per vector. It then samples the DUT response against a reference-model expectation and accumulates a mismatch count, the first failing vector and a rotate-XOR response signature. It sits between a combinational DUT (and its golden model) and the on-board test controller. It replaces hand-written sweep loops with a clocked block usable in simulation and on silicon.

## Interface
- N_IN, 4, DUT input width; sweep covers 2^N_IN vectors (1..16)
- N_OUT, 1, DUT output width (must be ≤ SIG_W)
- SETTLE, 1, cycles each vector is held before sampling (≥1)
- SIG_W, 16, signature register width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; honoured only in IDLE
- abort  in  1  terminate a running sweep
- stim  out  N_IN  vector driven to DUT and golden model
- resp  in  N_OUT  DUT output
- exp  in  N_OUT  golden-model output for current stim
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on normal completion
- err_cnt  out  N_IN+1  number of vectors with resp≠exp
- fail_valid  out  1  at least one mismatch this sweep
- first_fail  out  N_IN  stim of first mismatch (valid when fail_valid)
- signature  out  SIG_W  response signature

## Operation
- Reset: state IDLE; stim=0, busy=0, done=0, err_cnt=0, fail_valid=0, first_fail=0, signature=0, settle counter=0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: start=1 → stim=0, err_cnt=0, fail_valid=0, first_fail=0, signature=0, counter=0, go APPLY. The previous sweep's results hold until this edge.
- APPLY: held SETTLE cycles (counter 0..SETTLE-1), then SAMPLE.
- SAMPLE (one cycle):
  - At the exiting edge, compare resp vs exp.
  - On mismatch, err_cnt+1. If fail_valid=0, first_fail=stim and fail_valid=1.
  - signature = {signature[SIG_W-2:0], signature[SIG_W-1]} XOR zero-extended resp.
  - If stim=2^N_IN-1, go DONE and stim wraps to 0. Otherwise stim+1, counter=0, go APPLY.
- DONE (one cycle): done=1, busy=0. Next edge go IDLE.
- busy=1 in APPLY and SAMPLE only.
- abort=1 in APPLY/SAMPLE:
  - Next edge goes IDLE with stim=0 and no done pulse.
  - That edge performs no SAMPLE update.
  - err_cnt, fail_valid, first_fail and signature keep their partial values.
- abort=1 in IDLE/DONE: no effect. abort outranks a simultaneous SAMPLE completion.
- start while busy or in DONE: ignored.
- rst at any time: immediate return to reset values; any sweep in flight is lost.
- err_cnt width N_IN+1 holds the full 2^N_IN count without wrap.

## Timing
- Start accepted at edge E0. stim=0 and busy=1 are visible after E0.
- Vector k is stable from E0+k·(SETTLE+1) until E0+(k+1)·(SETTLE+1). resp/exp are sampled at the latter edge.
- Let T = 2^N_IN·(SETTLE+1).
  - done=1 in the cycle after E0+T; results are final and visible in that same cycle.
  - IDLE at E0+T+1; the earliest restart is start sampled at E0+T+1.
- resp and exp must be combinational functions of stim settling within SETTLE cycles. The block does not register stim-to-resp paths.

## Test plan
- N_IN=4, SETTLE=1, DUT=golden=parity(stim), start pulse → busy 32 cycles, done at cycle 33 after E0; err_cnt=0, fail_valid=0.
- Same setup, DUT output inverted only for stim=5 and stim=12 → err_cnt=2, fail_valid=1, first_fail=5.
- resp tied to 1, SIG_W=16, N_IN=4 → signature=0xFFFF at done. Intermediate value after k vectors is 2^k−1.
- SETTLE=3, N_IN=4 → each vector held exactly 3 cycles before sampling, done 64 cycles after E0; start asserted mid-sweep changes nothing.
- abort while stim=7 (mismatch injected at stim=3) → IDLE next edge, no done, stim=0, err_cnt=1, first_fail=3. A fresh start clears results and runs a full 32-cycle sweep.
- rst asserted asynchronously mid-SAMPLE at stim=9 → all outputs at reset values immediately, without waiting for a clock edge; next start sweeps from stim=0.
